// File: rtl/core_pkg.sv
// Shared core types: opcode encoding, immediate formats and decode-stage FSM states.
package core_pkg;

  localparam int INSTR_W = 32;

  // Raw 7-bit major opcode as seen by the control unit.
  typedef logic [6:0] opcode_t;

  localparam opcode_t OP_LOAD   = 7'h03;
  localparam opcode_t OP_OP_IMM = 7'h13;
  localparam opcode_t OP_AUIPC  = 7'h17;
  localparam opcode_t OP_STORE  = 7'h23;
  localparam opcode_t OP_OP     = 7'h33;
  localparam opcode_t OP_LUI    = 7'h37;
  localparam opcode_t OP_BRANCH = 7'h63;
  localparam opcode_t OP_JALR   = 7'h67;
  localparam opcode_t OP_JAL    = 7'h6F;

  // Immediate format selected by the control unit; encodings 5..7 are undefined.
  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_src_t;

  // Occupancy of the decode pipeline register plus its skid entry.
  typedef enum logic [1:0] {
    DS_EMPTY = 2'd0,
    DS_FULL  = 2'd1,
    DS_SKID  = 2'd2
  } ds_state_t;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-to-decode valid/ready channel carrying PC, PC+4 and the instruction word.
interface decode_stage_if #(
  parameter int XLEN = 32
);
  import core_pkg::*;

  logic               valid;
  logic               ready;
  logic [XLEN-1:0]    pc;
  logic [XLEN-1:0]    pc_plus_4;
  logic [INSTR_W-1:0] instruction;

  // Fetch drives the payload, decode answers with ready.
  modport master (output valid, pc, pc_plus_4, instruction, input ready);
  modport slave  (input valid, pc, pc_plus_4, instruction, output ready);

endinterface

// File: rtl/decode_regfile.sv
// Architectural register file: two combinational read ports, one write port,
// x0 hardwired to zero, optional same-cycle write-to-read forwarding.
module decode_regfile #(
  parameter int  XLEN     = 32,
  parameter int  NUM_REGS = 32,
  parameter bit  BYPASS   = 1'b1,
  localparam int REG_AW   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  output logic [XLEN-1:0]   rs1_value,
  output logic [XLEN-1:0]   rs2_value,
  input  logic [REG_AW-1:0] w_rd,
  input  logic [XLEN-1:0]   w_result,
  input  logic              w_reg_write
);

  logic [XLEN-1:0] regs [NUM_REGS];

  // Register write; the whole array clears on reset.
  // NOTE: every entry is in the reset branch so a mid-run reset really empties
  // the file; a memory left out of reset would hold stale data across it.
  // NOTE: state is updated with <= so all flops sample pre-edge values together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (w_reg_write && (w_rd != '0)) begin
      regs[w_rd] <= w_result;
    end
  end

  // Combinational read with x0 forced to zero and optional forwarding.
  // NOTE: outputs get a default first so no path leaves them unassigned (latch).
  always_comb begin
    rs1_value = '0;
    rs2_value = '0;
    if (rs1 != '0) begin
      if (BYPASS && w_reg_write && (w_rd == rs1)) rs1_value = w_result;
      else                                        rs1_value = regs[rs1];
    end
    if (rs2 != '0) begin
      if (BYPASS && w_reg_write && (w_rd == rs2)) rs2_value = w_result;
      else                                        rs2_value = regs[rs2];
    end
  end

endmodule

// File: rtl/decode_stage.sv
// RISC-V decode stage: registered fetch handshake with a one-entry skid buffer,
// field split for the control unit, register file read and immediate generation.
module decode_stage
  import core_pkg::*;
#(
  parameter int  XLEN     = 32,
  parameter int  NUM_REGS = 32,
  parameter bit  BYPASS   = 1'b1,
  localparam int REG_AW   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  decode_stage_if.slave     f_bus,
  input  logic              d_flush,
  input  logic              e_ready,
  output logic              d_valid,
  output opcode_t           op,
  output logic [2:0]        funct3,
  output logic [6:0]        funct7,
  input  imm_src_t          d_imm_src,
  output logic [XLEN-1:0]   d_pc,
  output logic [XLEN-1:0]   d_pc_plus_4,
  output logic [REG_AW-1:0] d_rs1,
  output logic [REG_AW-1:0] d_rs2,
  output logic [REG_AW-1:0] d_rd,
  output logic [XLEN-1:0]   d_rs1_value,
  output logic [XLEN-1:0]   d_rs2_value,
  output logic [XLEN-1:0]   d_imm_ext,
  input  logic [REG_AW-1:0] w_rd,
  input  logic [XLEN-1:0]   w_result,
  input  logic              w_reg_write
);

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    pc_plus_4;
    logic [INSTR_W-1:0] instruction;
  } payload_t;

  ds_state_t state_q, state_d;
  payload_t  main_q, skid_q, f_payload;
  logic      load_main, load_skid, main_from_skid;

  assign f_payload   = '{pc: f_bus.pc, pc_plus_4: f_bus.pc_plus_4, instruction: f_bus.instruction};

  // Handshake outputs depend on registered state only, so back-pressure is never combinational.
  assign f_bus.ready = (state_q != DS_SKID);
  assign d_valid     = (state_q != DS_EMPTY);

  // Next-state and payload-load decisions; flush wins over every transfer.
  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      DS_EMPTY: begin
        if (f_bus.valid) begin
          load_main = 1'b1;
          state_d   = DS_FULL;
        end
      end
      DS_FULL: begin
        if (f_bus.valid && e_ready) begin
          load_main = 1'b1;
        end else if (f_bus.valid) begin
          load_skid = 1'b1;
          state_d   = DS_SKID;
        end else if (e_ready) begin
          state_d   = DS_EMPTY;
        end
      end
      DS_SKID: begin
        if (e_ready) begin
          load_main      = 1'b1;
          main_from_skid = 1'b1;
          state_d        = DS_FULL;
        end
      end
      default: state_d = DS_EMPTY;
    endcase
    if (d_flush) begin
      state_d   = DS_EMPTY;
      load_main = 1'b0;
      load_skid = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= DS_EMPTY;
    else       state_q <= state_d;
  end

  // MAIN and SKID payload registers; flush only retires state, payload is left as is.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main) main_q <= main_from_skid ? skid_q : f_payload;
      if (load_skid) skid_q <= f_payload;
    end
  end

  logic [4:0] rs1_raw, rs2_raw, rd_raw;

  assign {funct7, rs2_raw, rs1_raw, funct3, rd_raw, op} = main_q.instruction;
  assign d_rs1       = rs1_raw[REG_AW-1:0];
  assign d_rs2       = rs2_raw[REG_AW-1:0];
  assign d_rd        = rd_raw[REG_AW-1:0];
  assign d_pc        = main_q.pc;
  assign d_pc_plus_4 = main_q.pc_plus_4;

  // Immediate built as a signed 32-bit value, then sign-extended to XLEN.
  logic [INSTR_W-1:0] instr;
  logic [31:0]        imm32;

  assign instr = main_q.instruction;

  always_comb begin
    imm32 = '0;
    case (d_imm_src)
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_J:   imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign d_imm_ext = XLEN'($signed(imm32));

  decode_regfile #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS),
    .BYPASS   (BYPASS)
  ) u_regfile (
    .clk         (clk),
    .reset       (reset),
    .rs1         (d_rs1),
    .rs2         (d_rs2),
    .rs1_value   (d_rs1_value),
    .rs2_value   (d_rs2_value),
    .w_rd        (w_rd),
    .w_result    (w_result),
    .w_reg_write (w_reg_write)
  );

endmodule
